// File: rtl/axicb_resp_router.sv
// Routes slave response bursts back to the requester whose grant was recorded at issue time.
// Latency: zero cycles slave->master (data and handshake); a pushed grant is routable one cycle later.
// Backpressure: s_ready follows m_ready of the head requester; held low while the tracker is empty.
module axicb_resp_router #(
    parameter int REQ_NB      = 4,
    parameter int OSTDREQ_NUM = 4,
    parameter int DATA_W      = 8
) (
    input  logic              aclk,
    input  logic              srst,
    input  logic [REQ_NB-1:0] grant,
    input  logic              grant_en,
    output logic              full,
    output logic              empty,
    output logic              err,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic [REQ_NB-1:0] m_valid,
    input  logic [REQ_NB-1:0] m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last
);
    localparam int IDX_W = $clog2(REQ_NB);
    localparam int PTR_W = $clog2(OSTDREQ_NUM);
    localparam int CNT_W = $clog2(OSTDREQ_NUM + 1);

    logic [IDX_W-1:0] mem_q [OSTDREQ_NUM];
    logic [IDX_W-1:0] mem_d [OSTDREQ_NUM];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             err_q, err_d;

    logic             grant_onehot;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] head_idx;
    logic             push;
    logic             pop;
    logic             bad_push;

    assign m_data = s_data;
    assign m_last = s_last;
    assign full   = full_q;
    assign empty  = empty_q;
    assign err    = err_q;

    always_comb begin
        grant_onehot = (grant != '0) && ((grant & (grant - REQ_NB'(1))) == '0);
        grant_idx    = '0;
        for (int i = 0; i < REQ_NB; i++) begin
            if (grant[i]) grant_idx = IDX_W'(i);
        end

        head_idx = mem_q[rptr_q];
        m_valid  = '0;
        s_ready  = 1'b0;
        for (int i = 0; i < REQ_NB; i++) begin
            if (head_idx == IDX_W'(i)) begin
                m_valid[i] = s_valid & ~empty_q;
                s_ready    = ~empty_q & m_ready[i];
            end
        end

        // Full is judged on registered state, so a same-cycle pop never rescues a push.
        push     = grant_en & ~full_q & grant_onehot;
        bad_push = grant_en & (full_q | ~grant_onehot);
        pop      = s_valid & s_ready & s_last;

        mem_d = mem_q;
        if (push) mem_d[wptr_q] = grant_idx;
        wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        cnt_d   = cnt_q + CNT_W'(push) - CNT_W'(pop);
        full_d  = (cnt_d == CNT_W'(OSTDREQ_NUM));
        empty_d = (cnt_d == '0);
        err_d   = err_q | bad_push;
    end

    always_ff @(posedge aclk) begin
        if (srst) begin
            for (int i = 0; i < OSTDREQ_NUM; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < OSTDREQ_NUM; i++) mem_q[i] <= mem_d[i];
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_axicb_resp_router.sv
// Directed bench for axicb_resp_router with hand-computed expectations.
module tb_axicb_resp_router;
    logic       aclk = 1'b0;
    logic       srst = 1'b0;
    logic [3:0] grant = '0;
    logic       grant_en = 1'b0;
    logic       full, empty, err;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic       s_last = 1'b0;
    logic [3:0] m_valid;
    logic [3:0] m_ready = 4'b1111;
    logic [7:0] m_data;
    logic       m_last;

    int checks   = 0;
    int failures = 0;

    axicb_resp_router #(.REQ_NB(4), .OSTDREQ_NUM(4), .DATA_W(8)) dut (
        .aclk(aclk), .srst(srst), .grant(grant), .grant_en(grant_en),
        .full(full), .empty(empty), .err(err),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] g);
        grant = g; grant_en = 1'b1;
        tick();
        grant_en = 1'b0; grant = '0;
    endtask

    logic [3:0] route_exp [4];
    logic [3:0] rdy_seq   [4];
    logic       last_seq  [4];

    initial begin
        // Reset and idle with s_valid high: slave must be back-pressured.
        srst = 1'b1; s_valid = 1'b1;
        tick();
        srst = 1'b0;
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_err", err, 0);
        chk("rst_m_valid", m_valid, 4'b0000);
        chk("rst_s_ready", s_ready, 0);
        s_valid = 1'b0;

        // Single push, single-beat response.
        push(4'b0100);
        chk("p1_empty", empty, 0);
        s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b1; m_ready = 4'b1111;
        #1;
        chk("p1_m_valid", m_valid, 4'b0100);
        chk("p1_m_data", m_data, 8'hA5);
        chk("p1_m_last", m_last, 1);
        chk("p1_s_ready", s_ready, 1);
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        chk("p1_empty_after", empty, 1);

        // Fill to capacity, overflow push, then drain in order.
        route_exp[0] = 4'b0001; route_exp[1] = 4'b1000;
        route_exp[2] = 4'b0010; route_exp[3] = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            chk("fill_full_before", full, 0);
            push(route_exp[i]);
        end
        chk("fill_full", full, 1);
        push(4'b0100);
        chk("ovf_err", err, 1);
        chk("ovf_full", full, 1);
        s_valid = 1'b1; s_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = 8'(8'h10 + i);
            #1;
            chk("drain_m_valid", m_valid, route_exp[i]);
            chk("drain_s_ready", s_ready, 1);
            tick();
            chk("drain_full", full, 0);
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("drain_empty", empty, 1);

        // 3-beat burst to requester 1 with m_ready[1] stalling once.
        push(4'b0010);
        rdy_seq[0] = 4'b1111; rdy_seq[1] = 4'b1101; rdy_seq[2] = 4'b1111; rdy_seq[3] = 4'b1111;
        last_seq[0] = 1'b0; last_seq[1] = 1'b0; last_seq[2] = 1'b0; last_seq[3] = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_ready = rdy_seq[i]; s_last = last_seq[i];
            #1;
            chk("burst_m_valid", m_valid, 4'b0010);
            chk("burst_s_ready", s_ready, rdy_seq[i][1]);
            chk("burst_empty", empty, 0);
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0; m_ready = 4'b1111;
        chk("burst_empty_after", empty, 1);

        // Simultaneous push and pop at count 2.
        push(4'b0001);
        push(4'b0100);
        grant = 4'b1000; grant_en = 1'b1; s_valid = 1'b1; s_last = 1'b1;
        #1;
        chk("sim_m_valid", m_valid, 4'b0001);
        tick();
        grant_en = 1'b0; grant = '0;
        chk("sim_empty", empty, 0);
        chk("sim_full", full, 0);
        chk("sim_head2", m_valid, 4'b0100);
        tick();
        chk("sim_tail", m_valid, 4'b1000);
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        chk("sim_empty_after", empty, 1);

        // Reset mid-burst with three entries outstanding; err was set earlier.
        push(4'b0001); push(4'b0010); push(4'b0100);
        s_valid = 1'b1; s_last = 1'b0;
        #1;
        chk("mid_m_valid", m_valid, 4'b0001);
        tick();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        chk("mrst_empty", empty, 1);
        chk("mrst_s_ready", s_ready, 0);
        chk("mrst_m_valid", m_valid, 4'b0000);
        chk("mrst_err", err, 0);
        chk("mrst_rptr", 32'(dut.rptr_q), 0);
        chk("mrst_wptr", 32'(dut.wptr_q), 0);
        s_valid = 1'b0;
        push(4'b0010);
        s_valid = 1'b1; s_last = 1'b1;
        #1;
        chk("post_m_valid", m_valid, 4'b0010);
        chk("post_s_ready", s_ready, 1);
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        chk("post_empty", empty, 1);
        chk("post_err", err, 0);

        // Non-one-hot and zero grants are dropped and flag an error.
        push(4'b0011);
        chk("bad2_empty", empty, 1);
        chk("bad2_err", err, 1);
        srst = 1'b1; tick(); srst = 1'b0;
        push(4'b0000);
        chk("bad0_empty", empty, 1);
        chk("bad0_err", err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axicb_resp_router.md
Name: axicb_resp_router

Overview:
- Return-path companion to the round-robin arbiter core.
- Records the one-hot grant of every request the arbiter issues into an in-order tracker FIFO.
- Steers the responses that come back from the shared slave port to the requester that issued them, one burst per entry, in issue order.
- Sits between a slave interface and the per-master response channels inside a crossbar switch.

Parameters:
- REQ_NB, 4, number of requesters; legal range 2..8.
- OSTDREQ_NUM, 4, maximum outstanding requests tracked; power of two, at least 2.
- DATA_W, 8, response payload width in bits.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- srst  in  1  synchronous active-high reset.
- grant  in  REQ_NB  one-hot grant from the arbiter.
- grant_en  in  1  request accepted downstream this cycle; push the grant.
- full  out  1  tracker holds OSTDREQ_NUM entries; the arbiter must stall.
- empty  out  1  tracker holds no entries.
- err  out  1  sticky protocol-error flag.
- s_valid  in  1  response beat valid from the slave side.
- s_ready  out  1  response beat accepted.
- s_data  in  DATA_W  response payload.
- s_last  in  1  final beat of a response burst.
- m_valid  out  REQ_NB  per-requester response valid.
- m_ready  in  REQ_NB  per-requester response ready.
- m_data  out  DATA_W  response payload, shared by all requesters; equals s_data.
- m_last  out  1  shared; equals s_last.

Behaviour:
- Reset (srst=1 at a rising edge):
  - Pointers and count cleared; empty=1, full=0, err=0.
  - m_valid=0 and s_ready=0 from the following cycle.
  - Takes priority over push and pop in the same cycle.
  - A burst in flight is abandoned; no beat is forwarded until a new entry is pushed.
- Storage:
  - FIFO of OSTDREQ_NUM entries, each holding the binary index of the granted requester ($clog2(REQ_NB) bits).
  - Count register is $clog2(OSTDREQ_NUM+1) bits wide.
  - Read and write pointers wrap modulo OSTDREQ_NUM.
- Push:
  - Occurs when grant_en=1, full=0 and grant is one-hot.
  - Stores the encoded index; count increments.
  - The new entry is visible at the head the next cycle; there is no same-cycle bypass.
- Rejected push:
  - grant_en=1 while full=1 is dropped and sets err.
  - This applies even if a pop happens in the same cycle: full is judged on registered state only.
  - grant_en=1 with grant zero or not one-hot is dropped and sets err.
- Routing, combinational from the head entry idx:
  - m_valid[idx] = s_valid & ~empty; all other m_valid bits are 0.
  - s_ready = ~empty & m_ready[idx].
  - When empty=1: s_ready=0 and m_valid=0, so the slave is back-pressured.
- Beat transfer: s_valid & s_ready.
- Pop:
  - Occurs on a transfer with s_last=1; read pointer advances and count decrements.
  - The next beat routes by the next entry from the following cycle.
- Simultaneous push and pop when not full: count unchanged; both pointers advance.
- Status flags:
  - full and empty are registered, derived from count.
  - full = (count==OSTDREQ_NUM); empty = (count==0).
- err:
  - Only srst clears it.
  - A pop while empty cannot occur, because s_ready=0 when empty.
- Latency: zero cycles from slave to master for data and handshake; one cycle from push to routability.

Test Plan:
- srst pulse, then idle → empty=1, full=0, err=0, m_valid=0000, s_ready=0 while s_valid=1.
- Push grant 0100, then one-beat response s_data=8'hA5, s_last=1, m_ready=1111 → m_valid=0100 and m_data=A5 in the same cycle; empty=1 the next cycle.
- Push 0001, 1000, 0010, 0001 on consecutive cycles → full=1 after the fourth. A fifth push of 0100 → dropped, err=1. Four single-beat responses route to 0001, 1000, 0010, 0001 in order.
- Push 0010, then a 3-beat burst with m_ready[1] toggling 1,0,1,1 → s_ready follows m_ready[1]; pop only on the last beat; count 1→0 exactly once.
- With count=2 (heads 0001, 0100), push 1000 in the same cycle as the last-beat pop of 0001 → count stays 2; the next head is 0100 and the tail is 1000.
- srst mid-burst with count=3 → the next cycle shows empty=1, s_ready=0 and pointers at 0. A subsequent push of 0010 routes correctly and err stays 0.
